// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per shift_en strobe with valid/frame markers.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               last_s;
    logic               accept_s;
    logic               out_bit_s;
    logic [WIDTH-1:0]   shifted_s;

    // Handshake decode: the last consumed bit reopens the input the same cycle.
    always_comb begin
        last_s     = (state_q == SHIFT) && (cnt_q == CNT_LAST) && shift_en;
        load_ready = !rst && ((state_q == IDLE) || last_s);
        accept_s   = load_valid && load_ready;
    end

    // Output-end selection and zero-filled shift toward the output end.
    always_comb begin
        if (LSB_FIRST) begin
            out_bit_s = sreg_q[0];
            shifted_s = {1'b0, sreg_q[WIDTH-1:1]};
        end else begin
            out_bit_s = sreg_q[WIDTH-1];
            shifted_s = {sreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state logic for the IDLE/SHIFT sequencer.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sreg_d  = load_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_q == CNT_LAST) begin
                        done_d = 1'b1;
                        if (accept_s) begin
                            sreg_d = load_data;
                            cnt_d  = '0;
                        end else begin
                            sreg_d  = shifted_s;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        sreg_d = shifted_s;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset aborts any word in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Serial outputs decoded straight from registered state.
    always_comb begin
        sout_valid = (state_q == SHIFT);
        busy       = (state_q == SHIFT);
        sout       = (state_q == SHIFT) && out_bit_s;
        frame      = (state_q == SHIFT) && (cnt_q == '0);
        done       = done_q;
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: an LSB-first and an MSB-first instance
// share stimulus; a word-level model predicts the serial stream of each.
module tb_piso_shift_tx;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } item_t;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         shift_en;
    logic [1:0]   ready_v, sout_v, valid_v, frame_v, busy_v, done_v;

    item_t q0[$];
    item_t q1[$];
    logic [1:0] exp_done;
    int rem;
    int n_tests;
    int n_fail;

    piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_v[0]), .shift_en(shift_en), .sout(sout_v[0]),
        .sout_valid(valid_v[0]), .frame(frame_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_v[1]), .shift_en(shift_en), .sout(sout_v[1]),
        .sout_valid(valid_v[1]), .frame(frame_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", nm, k, $time, act, exp_v);
        end
    endtask

    // Expected stream for one accepted word, for both bit orders.
    task automatic push_word(input logic [W-1:0] d);
        item_t it;
        for (int i = 0; i < W; i++) begin
            it.first = (i == 0);
            it.last  = (i == W - 1);
            it.b     = d[i];
            q0.push_back(it);
            it.b     = d[W-1-i];
            q1.push_back(it);
        end
    endtask

    // One clock of stimulus; rem = bits of the current word not yet consumed.
    task automatic step(input logic lv, input logic [W-1:0] d, input logic se);
        logic rdy;
        logic acc;
        load_valid = lv;
        load_data  = d;
        shift_en   = se;
        #1;
        rdy = (rem == 0) || (rem == 1 && se);
        for (int k = 0; k < 2; k++) begin
            chk("load_ready", k, 32'(ready_v[k]), 32'(rdy));
            chk("sout_valid", k, 32'(valid_v[k]), 32'(rem > 0));
        end
        acc = lv && rdy;
        if (acc) push_word(d);
        @(posedge clk);
        if (acc) rem = W;
        else if (se && rem > 0) rem = rem - 1;
        #1;
    endtask

    // Monitor: compares each presented bit against the queue head.
    always @(negedge clk) begin
        item_t it;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk("done", k, 32'(done_v[k]), 32'(exp_done[k]));
                exp_done[k] = 1'b0;
                chk("busy", k, 32'(busy_v[k]), 32'(valid_v[k]));
                if (valid_v[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        chk("unexpected_bit", k, 32'(1), 32'(0));
                    end else begin
                        it = (k == 0) ? q0[0] : q1[0];
                        chk("sout", k, 32'(sout_v[k]), 32'(it.b));
                        chk("frame", k, 32'(frame_v[k]), 32'(it.first));
                        if (shift_en) begin
                            if (k == 0) void'(q0.pop_front());
                            else void'(q1.pop_front());
                            if (it.last) exp_done[k] = 1'b1;
                        end
                    end
                end else begin
                    chk("idle_sout", k, 32'(sout_v[k]), 32'(0));
                    chk("idle_frame", k, 32'(frame_v[k]), 32'(0));
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        rem = 0;
        exp_done = 2'b00;
        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        shift_en = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, 32'(ready_v[k]), 32'(0));
            chk("rst_outs", k, 32'({sout_v[k], valid_v[k], frame_v[k], busy_v[k], done_v[k]}), 32'(0));
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Test 1/2: 0xA5 then 0x01 with continuous shift_en
        step(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // Test 3: back-to-back words with load_valid held high
        step(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // Test 4: stall three cycles after bit 2
        step(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);

        // Test 6: mid-word load pulse must be ignored
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h99, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

        // Test 5: asynchronous reset during bit 4 of 0x55
        step(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("abort_outs", k, 32'({sout_v[k], valid_v[k], busy_v[k], frame_v[k]}), 32'(0));
            chk("abort_ready", k, 32'(ready_v[k]), 32'(0));
        end
        q0.delete();
        q1.delete();
        rem = 0;
        exp_done = 2'b00;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk("abort_done", k, 32'(done_v[k]), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 8'h0F, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0), W'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);

        chk("drain_q", 0, 32'(q0.size()), 32'(0));
        chk("drain_q", 1, 32'(q1.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in, serial-out transmitter for the flip-flop library. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock on a single serial line, with valid and frame markers. It is the sending end for serial-in capture chains built from the library's D flip-flops. A receiver samples sout on every rising clk edge where sout_valid and shift_en are both 1.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
load_valid  input  1  load_data holds a word to send.
load_data  input  WIDTH  parallel word; sampled only on the accept edge.
load_ready  output  1  combinational; the block can accept a word this cycle.
shift_en  input  1  bit-pacing strobe; the current bit is consumed on an edge only while this is 1.
sout  output  1  serial data bit currently presented.
sout_valid  output  1  sout carries a valid bit.
frame  output  1  high while the first bit of a word is presented.
busy  output  1  state is SHIFT.
done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset (asynchronous, immediate on rst=1): state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, frame=0, busy=0, done=0. load_ready is 0 while rst=1 and 1 in the first cycle after rst deasserts.
- The bit counter is $clog2(WIDTH) bits wide and runs 0..WIDTH-1.
- States:
  - IDLE: load_ready=1. On an edge with load_valid=1, the word is accepted: the register loads load_data, the counter is set to 0, and the state goes to SHIFT.
  - SHIFT: sout_valid=1 and busy=1. sout is register bit 0 (LSB_FIRST=1) or bit WIDTH-1 (LSB_FIRST=0). frame=1 only while the counter is 0.
- On an edge with shift_en=1 in SHIFT, the register shifts toward the output end, zero-filled, and the counter increments.
- On an edge with shift_en=0 in SHIFT, sout, the counter and frame all hold.
- Latency: the first bit appears on sout in the cycle after the accept edge.
- Last bit (counter = WIDTH-1 and shift_en=1):
  - load_ready=1 combinationally in this cycle.
  - If load_valid=1, the new word is loaded at that edge and SHIFT continues with the counter at 0. frame=1 on the next cycle and there is no idle gap.
  - Otherwise the state returns to IDLE: sout_valid=0 and sout=0 on the next cycle.
- done is registered. It is 1 for exactly one cycle after every edge that consumes a last bit, including back-to-back words.
- load_ready=0 in SHIFT except in the last-bit-with-shift_en case above. load_valid is ignored whenever load_ready=0.
- Changes to load_data after the accept edge have no effect on the word being sent.
- rst asserted mid-word aborts the word: outputs go to their reset values immediately and done does not pulse.
- shift_en is don't-care in IDLE.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, shift_en=1, load 0xA5 at edge E0 -> sout = 1,0,1,0,0,1,0,1 on cycles E0+1..E0+8. frame=1 only on E0+1; sout_valid=1 for those 8 cycles. done=1 in cycle E0+9 only; sout_valid=0 and load_ready=1 in that cycle.
2. LSB_FIRST=0, load 0xA5 -> sout = 1,0,1,0,0,1,0,1 MSB first. Then load 0x01 -> sout = 0,0,0,0,0,0,0,1.
3. load_valid held high with 0x3C then 0xC3 -> 16 consecutive valid bits (0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1). frame=1 at bit 0 and bit 8; done pulses twice; sout_valid never drops.
4. load 0xFF, then shift_en=0 for 3 cycles after bit 2 -> sout and frame hold, counter frozen, load_ready=0. The word completes 3 cycles late and done is still a single pulse.
5. rst=1 asynchronously during bit 4 of 0x55 -> sout_valid=0, sout=0 and busy=0 before the next edge, with no done pulse. After release, load 0x0F -> sout = 1,1,1,1,0,0,0,0 from a clean start.
6. While busy, pulse load_valid with 0x99 mid-word -> the pulse is ignored (load_ready=0). The word in flight is unchanged and 0x99 is never transmitted.
